// File: rtl/audio_pkg.sv
// Shared audio-subsystem definitions.
//   WL16/WL24/WL32 : word_len encodings (code 3 behaves as 32 bits)
//   wl_bits()      : maps a word_len code to the number of captured bits
//   i2s_rx_state_e : receiver FSM states
package audio_pkg;

    localparam logic [1:0] WL16 = 2'd0;
    localparam logic [1:0] WL24 = 2'd1;
    localparam logic [1:0] WL32 = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        SHIFT = 2'd2
    } i2s_rx_state_e;

    function automatic logic [5:0] wl_bits(input logic [1:0] code);
        case (code)
            WL16:    return 6'd16;
            WL24:    return 6'd24;
            default: return 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/i2s_sync.sv
// Multi-flop synchronizer for the I2S lines plus an SCK rising-edge strobe.
//   clk, rst_n              : system clock, asynchronous active-low reset
//   i2s_sck/i2s_ws/i2s_sd   : raw pins, asynchronous to clk
//   sck_sync/ws_sync/sd_sync: synchronized copies, equal latency
//   sck_rise                : one-cycle strobe on a synchronized SCK 0->1
module i2s_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i2s_sck,
    input  logic i2s_ws,
    input  logic i2s_sd,
    output logic sck_sync,
    output logic ws_sync,
    output logic sd_sync,
    output logic sck_rise
);

    logic [SYNC_STAGES-1:0] sck_p0;
    logic [SYNC_STAGES-1:0] ws_p0;
    logic [SYNC_STAGES-1:0] sd_p0;
    logic                   sck_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_p0 <= '0;
            ws_p0  <= '0;
            sd_p0  <= '0;
            sck_p1 <= 1'b0;
        end else begin
            sck_p0 <= {sck_p0[SYNC_STAGES-2:0], i2s_sck};
            ws_p0  <= {ws_p0[SYNC_STAGES-2:0], i2s_ws};
            sd_p0  <= {sd_p0[SYNC_STAGES-2:0], i2s_sd};
            // extra SCK stage: previous synchronized value for edge detection
            sck_p1 <= sck_p0[SYNC_STAGES-1];
        end
    end

    assign sck_sync = sck_p0[SYNC_STAGES-1];
    assign ws_sync  = ws_p0[SYNC_STAGES-1];
    assign sd_sync  = sd_p0[SYNC_STAGES-1];
    assign sck_rise = sck_p0[SYNC_STAGES-1] & ~sck_p1;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserializes MSB-first words (standard one-bit-delay framing)
// into MSB-aligned 32-bit PCM words, interleaved L/R, valid-only stream.
//   clk, rst_n      : system clock (>= 6x SCK), asynchronous active-low reset
//   enable          : low forces IDLE and clears outputs / error count
//   word_len        : 0=16, 1=24, 2/3=32 bits; latched at each channel start
//   i2s_sck/ws/sd   : codec serial lines (asynchronous)
//   pcm_dout        : received word, LSBs zero-padded, held between pulses
//   pcm_dout_valid  : one-cycle pulse per word
//   pcm_dout_ch     : channel of pcm_dout (0=L, 1=R)
//   frame_err       : one-cycle pulse on short word or sync timeout
//   err_cnt         : saturating count of frame_err pulses
module i2s_rx
    import audio_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         word_len,
    input  logic               i2s_sck,
    input  logic               i2s_ws,
    input  logic               i2s_sd,
    output logic signed [31:0] pcm_dout,
    output logic               pcm_dout_valid,
    output logic               pcm_dout_ch,
    output logic               frame_err,
    output logic [7:0]         err_cnt
);

    localparam logic [6:0] TO_LAST = 7'(TIMEOUT_BITS - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    logic sck_sync, ws, sd, sck_rise;

    i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i2s_sck  (i2s_sck),
        .i2s_ws   (i2s_ws),
        .i2s_sd   (i2s_sd),
        .sck_sync (sck_sync),
        .ws_sync  (ws),
        .sd_sync  (sd),
        .sck_rise (sck_rise)
    );

    i2s_rx_state_e      state, state_nxt;
    logic signed [31:0] shreg, shreg_nxt, shreg_cap, dout_nxt;
    logic [5:0]         bit_cnt, bit_cnt_nxt, cnt_inc, n_bits;
    logic [4:0]         idx;
    logic [1:0]         len_q, len_q_nxt;
    logic               ws_prev, ws_prev_nxt, chan, chan_nxt;
    logic               ch_nxt, valid_nxt, ferr_nxt;
    logic [7:0]         err_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            len_q          <= WL32;
            ws_prev        <= 1'b1;
            chan           <= 1'b0;
            pcm_dout       <= '0;
            pcm_dout_ch    <= 1'b0;
            pcm_dout_valid <= 1'b0;
            frame_err      <= 1'b0;
            err_cnt        <= '0;
        end else begin
            state          <= state_nxt;
            shreg          <= shreg_nxt;
            bit_cnt        <= bit_cnt_nxt;
            len_q          <= len_q_nxt;
            ws_prev        <= ws_prev_nxt;
            chan           <= chan_nxt;
            pcm_dout       <= dout_nxt;
            pcm_dout_ch    <= ch_nxt;
            pcm_dout_valid <= valid_nxt;
            frame_err      <= ferr_nxt;
            err_cnt        <= err_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        len_q_nxt   = len_q;
        ws_prev_nxt = ws_prev;
        chan_nxt    = chan;
        dout_nxt    = pcm_dout;
        ch_nxt      = pcm_dout_ch;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
        err_cnt_nxt = err_cnt;

        n_bits  = wl_bits(len_q);
        cnt_inc = sat_inc6(bit_cnt);
        // 31 - bit_cnt for bit_cnt < 32; only used when bit_cnt < n_bits <= 32
        idx       = ~bit_cnt[4:0];
        shreg_cap = shreg;
        if (bit_cnt < n_bits) shreg_cap[idx] = sd;

        // WS history is tracked in every state so HUNT sees true 1->0 edges
        if (sck_rise) ws_prev_nxt = ws;

        if (!enable) begin
            state_nxt   = IDLE;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
            dout_nxt    = '0;
            ch_nxt      = 1'b0;
            err_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: state_nxt = HUNT;
                HUNT: begin
                    // this edge carries the right LSB; the left MSB follows
                    if (sck_rise && ws_prev && !ws) begin
                        shreg_nxt   = '0;
                        bit_cnt_nxt = '0;
                        chan_nxt    = 1'b0;
                        len_q_nxt   = word_len;
                        state_nxt   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        if (ws != ws_prev) begin
                            dout_nxt    = shreg_cap;
                            ch_nxt      = chan;
                            valid_nxt   = 1'b1;
                            ferr_nxt    = ({1'b0, bit_cnt} + 7'd1) < {1'b0, n_bits};
                            shreg_nxt   = '0;
                            bit_cnt_nxt = '0;
                            chan_nxt    = ws;
                            len_q_nxt   = word_len;
                        end else if ({1'b0, cnt_inc} >= TO_LAST) begin
                            // lost sync: drop the partial word and rehunt
                            ferr_nxt    = 1'b1;
                            shreg_nxt   = '0;
                            bit_cnt_nxt = '0;
                            state_nxt   = HUNT;
                        end else begin
                            shreg_nxt   = shreg_cap;
                            bit_cnt_nxt = cnt_inc;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (ferr_nxt) err_cnt_nxt = sat_inc8(err_cnt);
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: stimulus pushes expected words/errors,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_i2s_rx;

    logic               clk = 1'b0;
    logic               rst_n, enable, i2s_sck, i2s_ws, i2s_sd;
    logic [1:0]         word_len;
    logic signed [31:0] pcm_dout;
    logic               pcm_dout_valid, pcm_dout_ch, frame_err;
    logic [7:0]         err_cnt;

    always #5 clk = ~clk;

    i2s_rx #(.SYNC_STAGES(2), .TIMEOUT_BITS(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .word_len       (word_len),
        .i2s_sck        (i2s_sck),
        .i2s_ws         (i2s_ws),
        .i2s_sd         (i2s_sd),
        .pcm_dout       (pcm_dout),
        .pcm_dout_valid (pcm_dout_valid),
        .pcm_dout_ch    (pcm_dout_ch),
        .frame_err      (frame_err),
        .err_cnt        (err_cnt)
    );

    typedef struct {
        logic        valid;
        logic        err;
        logic [31:0] data;
        logic        ch;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic ch, input logic [31:0] d, input logic err);
        exp_q.push_back('{valid: 1'b1, err: err, data: d, ch: ch});
    endtask

    task automatic expect_err_only();
        exp_q.push_back('{valid: 1'b0, err: 1'b1, data: 32'h0, ch: 1'b0});
    endtask

    // one SCK period (= 8 clk): data changes while SCK low, sampled on the rise
    task automatic send_bit(input logic w, input logic d);
        i2s_sck = 1'b0;
        i2s_ws  = w;
        i2s_sd  = d;
        #40;
        i2s_sck = 1'b1;
        #40;
    endtask

    // WS flips on the LSB slot (one-bit delay framing)
    task automatic send_word(input logic ch, input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++)
            send_bit((i == n - 1) ? ~ch : ch, data[n-1-i]);
    endtask

    // WS high then a 1->0 edge: gives HUNT its start point
    task automatic preamble();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
    endtask

    task automatic restart(input logic [1:0] wl);
        enable = 1'b0;
        @(posedge clk);
        #1;
        word_len = wl;
        enable   = 1'b1;
        repeat (3) @(posedge clk);
        #3;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (pcm_dout_valid === 1'b1 || frame_err === 1'b1)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: valid=%0b err=%0b data=0x%08h ch=%0b, required no output",
                         pcm_dout_valid, frame_err, pcm_dout, pcm_dout_ch);
            end else begin
                mon_e = exp_q.pop_front();
                if (pcm_dout_valid !== mon_e.valid || frame_err !== mon_e.err ||
                    (mon_e.valid && (pcm_dout !== mon_e.data || pcm_dout_ch !== mon_e.ch))) begin
                    n_fail++;
                    $display("FAIL word: got valid=%0b err=%0b data=0x%08h ch=%0b, expected valid=%0b err=%0b data=0x%08h ch=%0b",
                             pcm_dout_valid, frame_err, pcm_dout, pcm_dout_ch,
                             mon_e.valid, mon_e.err, mon_e.data, mon_e.ch);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        word_len = 2'd2;
        i2s_sck  = 1'b0;
        i2s_ws   = 1'b1;
        i2s_sd   = 1'b0;
        #23;
        check("reset_dout",  pcm_dout,       32'h0);
        check("reset_valid", pcm_dout_valid, 32'h0);
        check("reset_ch",    pcm_dout_ch,    32'h0);
        check("reset_ferr",  frame_err,      32'h0);
        check("reset_errcnt", err_cnt,       32'h0);
        rst_n = 1'b1;
        #20;

        // 32-bit stereo, first word must be L
        restart(2'd2);
        preamble();
        for (int f = 0; f < 4; f++) begin
            expect_word(1'b0, 32'h12345678, 1'b0);
            send_word(1'b0, 32'h12345678, 32);
            expect_word(1'b1, 32'h87654321, 1'b0);
            send_word(1'b1, 32'h87654321, 32);
        end
        #100;
        check("stereo_errcnt", err_cnt, 32'h0);

        // 16-bit words inside 32-bit slots: trailing bits ignored
        restart(2'd0);
        preamble();
        expect_word(1'b0, 32'hA5A50000, 1'b0);
        send_word(1'b0, 32'hA5A51234, 32);
        expect_word(1'b1, 32'h5A5A0000, 1'b0);
        send_word(1'b1, 32'h5A5AFFFF, 32);
        #100;
        check("w16_errcnt", err_cnt, 32'h0);

        // short word: 24 bits while 32 expected
        restart(2'd2);
        preamble();
        expect_word(1'b0, 32'hFFFFFF00, 1'b1);
        send_word(1'b0, 32'h00FFFFFF, 24);
        #100;
        check("short_errcnt", err_cnt, 32'h1);
        expect_word(1'b1, 32'h80000001, 1'b0);
        send_word(1'b1, 32'h80000001, 32);
        #100;
        check("short_errcnt_hold", err_cnt, 32'h1);

        // enable while mid right word: nothing until WS 1->0
        enable = 1'b0;
        repeat (10) send_bit(1'b1, 1'b1);
        enable = 1'b1;
        repeat (21) send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        expect_word(1'b0, 32'hCAFEF00D, 1'b0);
        send_word(1'b0, 32'hCAFEF00D, 32);
        expect_word(1'b1, 32'h0BADC0DE, 1'b0);
        send_word(1'b1, 32'h0BADC0DE, 32);
        #100;
        check("midstart_errcnt", err_cnt, 32'h0);

        // timeout: WS stuck low for 70 edges
        expect_err_only();
        repeat (70) send_bit(1'b0, 1'b1);
        #100;
        check("timeout_errcnt", err_cnt, 32'h1);
        preamble();
        expect_word(1'b0, 32'h13579BDF, 1'b0);
        send_word(1'b0, 32'h13579BDF, 32);
        expect_word(1'b1, 32'h2468ACE0, 1'b0);
        send_word(1'b1, 32'h2468ACE0, 32);

        // enable drop mid-word
        for (int i = 0; i < 16; i++) send_bit(1'b0, i[0]);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("dis_dout",   pcm_dout,       32'h0);
        check("dis_valid",  pcm_dout_valid, 32'h0);
        check("dis_ferr",   frame_err,      32'h0);
        check("dis_errcnt", err_cnt,        32'h0);
        restart(2'd2);
        preamble();
        expect_word(1'b0, 32'h0F0F0F0F, 1'b0);
        send_word(1'b0, 32'h0F0F0F0F, 32);

        // asynchronous reset mid right word
        repeat (10) send_bit(1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_dout",  pcm_dout,       32'h0);
        check("rst_valid", pcm_dout_valid, 32'h0);
        #20;
        rst_n = 1'b1;
        #20;
        preamble();
        expect_word(1'b0, 32'h76543210, 1'b0);
        send_word(1'b0, 32'h76543210, 32);
        expect_word(1'b1, 32'hFEDCBA98, 1'b0);
        send_word(1'b1, 32'hFEDCBA98, 32);

        #200;
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
